// File: rtl/fp_add_sub_arbiter_if.sv
// rtl/fp_add_sub_arbiter_if.sv - request/response bundle for the shared fp add/sub arbiter
interface fp_add_sub_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_opd1;
  logic [32*N_REQ-1:0] req_opd2;
  logic [N_REQ-1:0]    req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_res;
  logic [3:0]          rsp_flags;
  logic                busy;
  logic [CNT_W-1:0]    op_count;

  modport master (
    output req_valid, req_opd1, req_opd2, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags, busy, op_count
  );

  modport slave (
    input  req_valid, req_opd1, req_opd2, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags, busy, op_count
  );
endinterface

// File: rtl/fp_add_sub_arbiter.sv
// rtl/fp_add_sub_arbiter.sv - round-robin arbiter sharing one registered fp add/sub unit
module fp_add_sub_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_add_sub_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [ID_W-1:0]   idx;
  logic [N_REQ-1:0]  grant_oh;
  logic [31:0]       opd1_arr [N_REQ];
  logic [31:0]       opd2_arr [N_REQ];

  logic [31:0]       opd1_q, opd2_q;
  logic              op_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [31:0]       rsp_res_q;
  logic [3:0]        rsp_flags_q;
  logic [CNT_W-1:0]  op_count_q;

  logic [31:0]       fp_res;
  logic [3:0]        fp_flags;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      opd1_arr[i] = bus.req_opd1[32*i +: 32];
      opd2_arr[i] = bus.req_opd2[32*i +: 32];
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (state_q == IDLE && grant_any) grant_oh[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      opd1_q      <= '0;
      opd2_q      <= '0;
      op_q        <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_any) begin
          opd1_q   <= opd1_arr[grant_id];
          opd2_q   <= opd2_arr[grant_id];
          op_q     <= bus.req_op[grant_id];
          id_q     <= grant_id;
          rr_ptr_q <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_res_q   <= fp_res;
          rsp_flags_q <= fp_flags;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          op_count_q  <= op_count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;

  // Single-precision add/sub: denormal inputs flush to zero, result truncated.
  logic              sa, sb, sl, ss, eff_sub, a_big, sticky, lz_found;
  logic              nan_a, nan_b, inf_a, inf_b, ovf, unf, nan;
  logic [7:0]        ea, eb, el, es, diff;
  logic [30:0]       mag_a, mag_b;
  logic [23:0]       ml, ms;
  logic [26:0]       ms_ext, ms_sh;
  logic [27:0]       sum, norm;
  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic              unused_bits;

  always_comb begin
    sa     = opd1_q[31];
    sb     = opd2_q[31] ^ op_q;
    ea     = opd1_q[30:23];
    eb     = opd2_q[30:23];
    nan_a  = (ea == 8'hFF) && (opd1_q[22:0] != 23'd0);
    nan_b  = (eb == 8'hFF) && (opd2_q[22:0] != 23'd0);
    inf_a  = (ea == 8'hFF) && (opd1_q[22:0] == 23'd0);
    inf_b  = (eb == 8'hFF) && (opd2_q[22:0] == 23'd0);
    mag_a  = (ea == 8'h00) ? 31'd0 : opd1_q[30:0];
    mag_b  = (eb == 8'h00) ? 31'd0 : opd2_q[30:0];
    a_big  = (mag_a >= mag_b);
    sl     = a_big ? sa : sb;
    ss     = a_big ? sb : sa;
    el     = a_big ? mag_a[30:23] : mag_b[30:23];
    es     = a_big ? mag_b[30:23] : mag_a[30:23];
    ml     = {el != 8'd0, a_big ? mag_a[22:0] : mag_b[22:0]};
    ms     = {es != 8'd0, a_big ? mag_b[22:0] : mag_a[22:0]};
    diff   = el - es;
    ms_ext = {ms, 3'b000};
    if (diff >= 8'd27) begin
      ms_sh  = '0;
      sticky = |ms_ext;
    end else begin
      ms_sh  = ms_ext >> diff;
      sticky = |(ms_ext & ((27'd1 << diff) - 27'd1));
    end
    ms_sh[0] = ms_sh[0] | sticky;
    eff_sub  = sl ^ ss;
    sum = eff_sub ? ({1'b0, ml, 3'b000} - {1'b0, ms_sh})
                  : ({1'b0, ml, 3'b000} + {1'b0, ms_sh});

    lz       = '0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && sum[i]) begin
        lz       = 5'(26 - i);
        lz_found = 1'b1;
      end
    end

    if (sum[27]) begin
      norm  = sum >> 1;
      exp_n = $signed({2'b00, el}) + 10'sd1;
    end else begin
      norm  = sum << lz;
      exp_n = $signed({2'b00, el}) - $signed({5'd0, lz});
    end

    ovf    = 1'b0;
    unf    = 1'b0;
    nan    = 1'b0;
    fp_res = {sl, exp_n[7:0], norm[25:3]};
    if (nan_a || nan_b || (inf_a && inf_b && (sa ^ sb))) begin
      fp_res = 32'h7FC0_0000;
      nan    = 1'b1;
    end else if (inf_a) begin
      fp_res = {sa, 8'hFF, 23'd0};
    end else if (inf_b) begin
      fp_res = {sb, 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      fp_res = 32'd0;
    end else if (exp_n >= 10'sd255) begin
      fp_res = {sl, 8'hFF, 23'd0};
      ovf    = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      fp_res = {sl, 31'd0};
      unf    = 1'b1;
    end
    fp_flags    = {ovf, unf, nan, fp_res[30:0] == 31'd0};
    unused_bits = ^{norm[27:26], norm[2:0], lz_found};
  end
endmodule
